// File: rtl/fg_pkg.sv
// -----------------------------------------------------------------------------
// fg_pkg
// Shared definitions for the function-generator profile sequencer:
//   - sequencer state encoding (IDLE / LOAD / RUN)
//   - host write-select codes for the profile store
//   - default widths of a configuration word and of a dwell count
// No ports; imported by fg_profile_store and fg_profile_sequencer.
// -----------------------------------------------------------------------------
package fg_pkg;

  localparam int DEFAULT_CONFIG_REG_BITWIDTH = 64;
  localparam int DEFAULT_DWELL_BITWIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } fg_state_t;

  // wrSel codes; code 3 is accepted on the bus but writes nothing
  localparam logic [1:0] WR_CFG_LO = 2'd0;
  localparam logic [1:0] WR_CFG_HI = 2'd1;
  localparam logic [1:0] WR_DWELL  = 2'd2;

endpackage

// File: rtl/fg_profile_store.sv
// -----------------------------------------------------------------------------
// fg_profile_store
// Register file holding PROFILE_COUNT profiles, each a configuration word plus
// a dwell count. One synchronous host write port (32-bit slices selected by
// wr_sel) and one asynchronous read port indexed by the sequencer.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all)
//   wr_en, wr_profile   write strobe and target profile
//   wr_sel, wr_data     slice select (cfg low / cfg high / dwell) and data
//   rd_profile          read index
//   rd_cfg, rd_dwell    stored configuration word and dwell of rd_profile
// A write and a read of the same profile in one cycle returns the old value;
// the new value is visible after the edge.
// -----------------------------------------------------------------------------
module fg_profile_store
  import fg_pkg::*;
#(
  parameter int CONFIG_REG_BITWIDTH = DEFAULT_CONFIG_REG_BITWIDTH,
  parameter int PROFILE_COUNT       = 4,
  parameter int DWELL_BITWIDTH      = DEFAULT_DWELL_BITWIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(PROFILE_COUNT)-1:0] wr_profile,
  input  logic [1:0]                       wr_sel,
  input  logic [31:0]                      wr_data,
  input  logic [$clog2(PROFILE_COUNT)-1:0] rd_profile,
  output logic [CONFIG_REG_BITWIDTH-1:0]   rd_cfg,
  output logic [DWELL_BITWIDTH-1:0]        rd_dwell
);

  logic [CONFIG_REG_BITWIDTH-1:0] cfg_mem   [PROFILE_COUNT];
  logic [DWELL_BITWIDTH-1:0]      dwell_mem [PROFILE_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PROFILE_COUNT; i++) begin
        cfg_mem[i]   <= '0;
        dwell_mem[i] <= '0;
      end
    end else if (wr_en) begin
      case (wr_sel)
        WR_CFG_LO: cfg_mem[wr_profile][31:0] <= wr_data;
        WR_CFG_HI: cfg_mem[wr_profile][CONFIG_REG_BITWIDTH-1:32] <= wr_data[CONFIG_REG_BITWIDTH-33:0];
        WR_DWELL:  dwell_mem[wr_profile] <= wr_data[DWELL_BITWIDTH-1:0];
        default:   ;
      endcase
    end
  end

  assign rd_cfg   = cfg_mem[rd_profile];
  assign rd_dwell = dwell_mem[rd_profile];

endmodule

// File: rtl/fg_profile_sequencer.sv
// -----------------------------------------------------------------------------
// fg_profile_sequencer
// Steps the function generator through stored profiles 0..last, presenting
// each configuration word on CR_bus_o for its dwell count of output strobes.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wrEn_i, wrProfile_i, wrSel_i, wrData_i   host write into the profile store
//   start_i             start a sequence (only from IDLE)
//   stop_i              abort a running sequence (beats start and strobe)
//   loop_i, lastProfile_i  sequence options, latched when start is accepted
//   strobe_i            generator output-valid; each one consumes one dwell
//   CR_bus_o            shadow copy of the active configuration word
//   outputEnable_o      generator output enable
//   activeProfile_o     index of the profile on CR_bus_o
//   busy_o              high in LOAD or RUN
//   done_o              one-cycle pulse when a non-looping sequence completes
//   dbg_state_o         current FSM state (fg_state_t encoding)
// Strobe semantics: strobe_i is a qualifier, not a handshake. It is counted
// only in RUN; there is no back-pressure toward the generator.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module fg_profile_sequencer
  import fg_pkg::*;
#(
  parameter int CONFIG_REG_BITWIDTH = DEFAULT_CONFIG_REG_BITWIDTH,
  parameter int PROFILE_COUNT       = 4,
  parameter int DWELL_BITWIDTH      = DEFAULT_DWELL_BITWIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wrEn_i,
  input  logic [$clog2(PROFILE_COUNT)-1:0] wrProfile_i,
  input  logic [1:0]                       wrSel_i,
  input  logic [31:0]                      wrData_i,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic                             loop_i,
  input  logic [$clog2(PROFILE_COUNT)-1:0] lastProfile_i,
  input  logic                             strobe_i,
  output logic [CONFIG_REG_BITWIDTH-1:0]   CR_bus_o,
  output logic                             outputEnable_o,
  output logic [$clog2(PROFILE_COUNT)-1:0] activeProfile_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [1:0]                       dbg_state_o
);

  localparam int IDX_W = $clog2(PROFILE_COUNT);
  localparam logic [IDX_W-1:0]          IDX_ONE   = IDX_W'(1);
  localparam logic [DWELL_BITWIDTH-1:0] DWELL_ONE = DWELL_BITWIDTH'(1);

  fg_state_t                     state;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              last_q;
  logic                          loop_q;
  logic [DWELL_BITWIDTH-1:0]     dwell_cnt;
  logic [CONFIG_REG_BITWIDTH-1:0] cr_q;
  logic                          oe_q;
  logic [IDX_W-1:0]              active_q;
  logic                          busy_q;
  logic                          done_q;

  logic [CONFIG_REG_BITWIDTH-1:0] rd_cfg;
  logic [DWELL_BITWIDTH-1:0]      rd_dwell;
  logic [DWELL_BITWIDTH-1:0]      dwell_eff;

  fg_profile_store #(
    .CONFIG_REG_BITWIDTH (CONFIG_REG_BITWIDTH),
    .PROFILE_COUNT       (PROFILE_COUNT),
    .DWELL_BITWIDTH      (DWELL_BITWIDTH)
  ) u_store (
    .clk        (clk_i),
    .rst        (rst_i),
    .wr_en      (wrEn_i),
    .wr_profile (wrProfile_i),
    .wr_sel     (wrSel_i),
    .wr_data    (wrData_i),
    .rd_profile (idx),
    .rd_cfg     (rd_cfg),
    .rd_dwell   (rd_dwell)
  );

  // A stored dwell of zero still shows the profile for one strobe
  assign dwell_eff = (rd_dwell == '0) ? DWELL_ONE : rd_dwell;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      idx       <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      dwell_cnt <= '0;
      cr_q      <= '0;
      oe_q      <= 1'b0;
      active_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state  <= ST_LOAD;
            idx    <= '0;
            loop_q <= loop_i;
            last_q <= lastProfile_i;
            busy_q <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (stop_i) begin
            state  <= ST_IDLE;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            // Store read is asynchronous, so a host write landing on this
            // same edge is not seen here: the old word is captured.
            cr_q      <= rd_cfg;
            dwell_cnt <= dwell_eff;
            active_q  <= idx;
            oe_q      <= 1'b1;
            state     <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop_i) begin
            state  <= ST_IDLE;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (strobe_i) begin
            if (dwell_cnt == DWELL_ONE) begin
              if (idx < last_q) begin
                idx   <= idx + IDX_ONE;
                state <= ST_LOAD;
              end else if (loop_q) begin
                idx   <= '0;
                state <= ST_LOAD;
              end else begin
                state  <= ST_IDLE;
                oe_q   <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_ONE;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          oe_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign CR_bus_o        = cr_q;
  assign outputEnable_o  = oe_q;
  assign activeProfile_o = active_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign dbg_state_o     = state;

endmodule

// File: tb/tb_fg_profile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fg_profile_sequencer
// Each scenario pushes one stimulus word and one expected output word per
// clock into paired queues; its own loop drives the stimulus, samples the
// outputs 1 time unit after the rising edge and compares.
// Expected word layout: {CR_bus_o, outputEnable_o, busy_o, done_o, activeProfile_o}
// -----------------------------------------------------------------------------
module tb_fg_profile_sequencer;
  import fg_pkg::*;

  localparam int W = 69;
  localparam logic [63:0] P0  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P1  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] P1A = 64'hAAAA_AAAA_7654_3210;
  localparam logic [63:0] P1B = 64'h5555_5555_7654_3210;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_profile;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [1:0]  last_profile;
  logic        strobe;
  logic [63:0] cr_bus;
  logic        output_enable;
  logic [1:0]  active_profile;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  fg_profile_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .wrEn_i          (wr_en),
    .wrProfile_i     (wr_profile),
    .wrSel_i         (wr_sel),
    .wrData_i        (wr_data),
    .start_i         (start),
    .stop_i          (stop),
    .loop_i          (loop_en),
    .lastProfile_i   (last_profile),
    .strobe_i        (strobe),
    .CR_bus_o        (cr_bus),
    .outputEnable_o  (output_enable),
    .activeProfile_o (active_profile),
    .busy_o          (busy),
    .done_o          (done),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        rst;
    logic        start;
    logic        stop;
    logic        strobe;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [1:0]  wr_prof;
    logic [31:0] wr_data;
  } stim_t;

  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic stim_t st(input logic s_start, input logic s_stop, input logic s_strobe);
    stim_t s;
    s        = '0;
    s.start  = s_start;
    s.stop   = s_stop;
    s.strobe = s_strobe;
    return s;
  endfunction

  function automatic stim_t stw(input logic s_strobe, input logic [1:0] prof,
                                input logic [1:0] sel, input logic [31:0] data);
    stim_t s;
    s         = '0;
    s.strobe  = s_strobe;
    s.wr_en   = 1'b1;
    s.wr_prof = prof;
    s.wr_sel  = sel;
    s.wr_data = data;
    return s;
  endfunction

  function automatic stim_t str(input logic s_strobe);
    stim_t s;
    s        = '0;
    s.rst    = 1'b1;
    s.strobe = s_strobe;
    return s;
  endfunction

  function automatic logic [W-1:0] ex(input logic [63:0] cr, input logic oe, input logic b,
                                      input logic d, input logic [1:0] act);
    return {cr, oe, b, d, act};
  endfunction

  function automatic logic [W-1:0] observe();
    return {cr_bus, output_enable, busy, done, active_profile};
  endfunction

  task automatic push(input stim_t s, input logic [W-1:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic push_n(input int n, input stim_t s, input logic [W-1:0] e);
    for (int i = 0; i < n; i++) push(s, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input stim_t s);
    rst        = s.rst;
    start      = s.start;
    stop       = s.stop;
    strobe     = s.strobe;
    wr_en      = s.wr_en;
    wr_sel     = s.wr_sel;
    wr_profile = s.wr_prof;
    wr_data    = s.wr_data;
  endtask

  task automatic write_reg(input logic [1:0] prof, input logic [1:0] sel, input logic [31:0] data);
    drive(stw(1'b0, prof, sel, data));
    @(posedge clk); #1;
    drive(st(1'b0, 1'b0, 1'b0));
  endtask

  task automatic setup_profile(input logic [1:0] prof, input logic [63:0] cfg, input logic [31:0] dwell);
    write_reg(prof, WR_CFG_LO, cfg[31:0]);
    write_reg(prof, WR_CFG_HI, cfg[63:32]);
    write_reg(prof, WR_DWELL, dwell);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(str(1'b0));
    loop_en      = 1'b0;
    last_profile = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (observe() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", observe(), {W{1'b0}});
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    drive(st(1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
  endtask

  // p0 dwell 3, p1 dwell 2, last 1, no loop, strobe every cycle
  task automatic test_single_pass();
    logic [W-1:0] e, o;
    setup_profile(2'd0, P0, 32'd3);
    setup_profile(2'd1, P1, 32'd2);
    loop_en      = 1'b0;
    last_profile = 2'd1;
    push(st(1, 0, 1), ex(64'h0, 0, 1, 0, 2'd0));
    push_n(4, st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push_n(2, st(0, 0, 1), ex(P1, 1, 1, 0, 2'd1));
    push(st(0, 0, 1), ex(P1, 0, 0, 1, 2'd1));
    push_n(2, st(0, 0, 1), ex(P1, 0, 0, 0, 2'd1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single_pass step %0d: got %h want %h", i, o, e);
      end
    end
    drive(st(0, 0, 0));
  endtask

  // same profiles with loop; stop mid-RUN while the final strobe of p1 is present
  task automatic test_loop_stop();
    logic [W-1:0] e, o;
    loop_en      = 1'b1;
    last_profile = 2'd1;
    push(st(1, 0, 1), ex(P1, 0, 1, 0, 2'd1));
    push_n(4, st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push_n(3, st(0, 0, 1), ex(P1, 1, 1, 0, 2'd1));
    push_n(4, st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push_n(2, st(0, 0, 1), ex(P1, 1, 1, 0, 2'd1));
    push(st(0, 1, 1), ex(P1, 0, 0, 0, 2'd1));
    push_n(2, st(0, 0, 1), ex(P1, 0, 0, 0, 2'd1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL loop_stop step %0d: got %h want %h", i, o, e);
      end
    end
    drive(st(0, 0, 0));
  endtask

  // dwell 0 on p0, single-profile sequence: one strobe consumed then done
  task automatic test_dwell_zero();
    logic [W-1:0] e, o;
    write_reg(2'd0, WR_DWELL, 32'd0);
    loop_en      = 1'b0;
    last_profile = 2'd0;
    push(st(1, 0, 1), ex(P1, 0, 1, 0, 2'd1));
    push(st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push(st(0, 0, 1), ex(P0, 0, 0, 1, 2'd0));
    push_n(2, st(0, 0, 1), ex(P0, 0, 0, 0, 2'd0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL dwell_zero step %0d: got %h want %h", i, o, e);
      end
    end
    drive(st(0, 0, 0));
  endtask

  // shadow register vs. live writes, write during LOAD, strobe freeze
  task automatic test_shadow_write();
    logic [W-1:0] e, o;
    write_reg(2'd0, WR_DWELL, 32'd2);
    write_reg(2'd1, WR_DWELL, 32'd3);
    loop_en      = 1'b1;
    last_profile = 2'd1;
    push(st(1, 0, 1), ex(P0, 0, 1, 0, 2'd0));
    push_n(3, st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push(st(0, 0, 1), ex(P1, 1, 1, 0, 2'd1));
    push(stw(1, 2'd1, WR_CFG_HI, 32'hAAAA_AAAA), ex(P1, 1, 1, 0, 2'd1));
    push_n(2, st(0, 0, 1), ex(P1, 1, 1, 0, 2'd1));
    push_n(3, st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    // this edge is the LOAD of p1; the simultaneous write must not be seen
    push(stw(1, 2'd1, WR_CFG_HI, 32'h5555_5555), ex(P1A, 1, 1, 0, 2'd1));
    push_n(3, st(0, 0, 0), ex(P1A, 1, 1, 0, 2'd1));
    push_n(3, st(0, 0, 1), ex(P1A, 1, 1, 0, 2'd1));
    push(st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push(st(0, 1, 1), ex(P0, 0, 0, 0, 2'd0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL shadow_write step %0d: got %h want %h", i, o, e);
      end
    end
    drive(st(0, 0, 0));
  endtask

  // start+stop in IDLE, start during LOAD/RUN, reset mid-RUN, cleared storage
  task automatic test_controls();
    logic [W-1:0] e, o;
    loop_en      = 1'b0;
    last_profile = 2'd1;
    push(st(1, 1, 1), ex(P0, 0, 0, 0, 2'd0));
    push(st(0, 0, 1), ex(P0, 0, 0, 0, 2'd0));
    push(st(1, 0, 1), ex(P0, 0, 1, 0, 2'd0));
    push(st(0, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push_n(2, st(1, 0, 1), ex(P0, 1, 1, 0, 2'd0));
    push(st(1, 0, 1), ex(P1B, 1, 1, 0, 2'd1));
    push(str(1), ex(64'h0, 0, 0, 0, 2'd0));
    push(st(0, 0, 1), ex(64'h0, 0, 0, 0, 2'd0));
    push(st(1, 0, 1), ex(64'h0, 0, 1, 0, 2'd0));
    push(st(0, 0, 1), ex(64'h0, 1, 1, 0, 2'd0));
    push(st(0, 0, 1), ex(64'h0, 1, 1, 0, 2'd0));
    push(st(0, 0, 1), ex(64'h0, 1, 1, 0, 2'd1));
    push(st(0, 0, 1), ex(64'h0, 0, 0, 1, 2'd1));
    push(st(0, 0, 0), ex(64'h0, 0, 0, 0, 2'd1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL controls step %0d: got %h want %h", i, o, e);
      end
    end
    drive(st(0, 0, 0));
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    drive(str(1'b0));
    test_reset();
    test_single_pass();
    test_loop_stop();
    test_dwell_zero();
    test_shadow_write();
    test_controls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
